// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage built around an IDLE/WAIT handshake FSM.
// Define MEM_TIMEOUT_EN to abort any access that waits TIMEOUT cycles without mem_ack.
`ifndef LW
`define LW 4'b1000
`endif
`ifndef SW
`define SW 4'b1001
`endif

module mem_stage #(
    parameter int unsigned DSIZE   = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [3:0]       op,
    input  logic [DSIZE-1:0] alu_out,
    input  logic [DSIZE-1:0] store_data,
    input  logic [3:0]       wb_addr_in,
    input  logic             wb_en_in,
    output logic             mem_req,
    output logic             mem_we,
    output logic [DSIZE-1:0] mem_addr,
    output logic [DSIZE-1:0] mem_wdata,
    input  logic [DSIZE-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             valid_out,
    output logic [DSIZE-1:0] wb_data,
    output logic [3:0]       wb_addr_out,
    output logic             wb_en_out,
    output logic             stall,
    output logic             err
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e           state_q;
    logic [DSIZE-1:0] mem_addr_q, mem_wdata_q, wb_data_q;
    logic             mem_we_q, valid_out_q, wb_en_out_q, wb_en_lat_q;
    logic [3:0]       wb_addr_lat_q, wb_addr_out_q;
    logic             is_mem_op;
    logic             timeout_hit;

    assign is_mem_op = (op == `LW) || (op == `SW);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CntW-1:0] wait_cnt_q;
    logic            err_q;

    // The counter holds the number of ack-less WAIT cycles already completed.
    assign timeout_hit = (wait_cnt_q == CntW'(TIMEOUT - 1));
    assign err         = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_we_q      <= 1'b0;
            wb_addr_lat_q <= '0;
            wb_en_lat_q   <= 1'b0;
            valid_out_q   <= 1'b0;
            wb_data_q     <= '0;
            wb_addr_out_q <= '0;
            wb_en_out_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q    <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            valid_out_q <= 1'b0;
            wb_en_out_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (valid_in) begin
                        if (is_mem_op) begin
                            state_q       <= StWait;
                            mem_addr_q    <= alu_out;
                            mem_wdata_q   <= store_data;
                            mem_we_q      <= (op == `SW);
                            wb_addr_lat_q <= wb_addr_in;
                            wb_en_lat_q   <= wb_en_in;
`ifdef MEM_TIMEOUT_EN
                            wait_cnt_q    <= '0;
`endif
                        end else begin
                            valid_out_q   <= 1'b1;
                            wb_data_q     <= alu_out;
                            wb_addr_out_q <= wb_addr_in;
                            wb_en_out_q   <= wb_en_in;
                        end
                    end
                end
                StWait: begin
                    if (mem_ack) begin
                        state_q       <= StIdle;
                        valid_out_q   <= 1'b1;
                        wb_addr_out_q <= wb_addr_lat_q;
                        if (mem_we_q) begin
                            wb_data_q <= mem_addr_q;
                        end else begin
                            wb_data_q   <= mem_rdata;
                            wb_en_out_q <= wb_en_lat_q;
                        end
                    end else if (timeout_hit) begin
                        state_q       <= StIdle;
                        valid_out_q   <= 1'b1;
                        wb_addr_out_q <= wb_addr_lat_q;
                        wb_data_q     <= mem_addr_q;
`ifdef MEM_TIMEOUT_EN
                        err_q         <= 1'b1;
`endif
                    end else begin
`ifdef MEM_TIMEOUT_EN
                        wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_req     = (state_q == StWait);
    assign stall       = (state_q == StWait);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign valid_out   = valid_out_q;
    assign wb_data     = wb_data_q;
    assign wb_addr_out = wb_addr_out_q;
    assign wb_en_out   = wb_en_out_q;

endmodule
